// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the parametrised sequential ALU.
// Op and operand-control bit positions match the out_sel / in_sel port layout.
package alu_seq_pkg;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_OFF  = 2'b00,
    ST_IDLE = 2'b01,
    ST_EXEC = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int unsigned OP_ADD = 6;
  localparam int unsigned OP_SUB = 5;
  localparam int unsigned OP_AND = 4;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_XOR = 2;
  localparam int unsigned OP_NOT = 1;
  localparam int unsigned OP_MUL = 0;

  localparam int unsigned SEL_PERSIST = 2;
  localparam int unsigned SEL_LOAD    = 1;
  localparam int unsigned SEL_CLR     = 0;

  // An op is legal when exactly one select bit is set and MUL is only legal if built in.
  function automatic logic op_valid(input logic [OP_W-1:0] op, input logic mul_en);
    return $onehot(op) && (mul_en || !op[OP_MUL]);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per step, WIDTH steps.
// last_c flags the final step; prod_c is the product once that step is applied.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last_c,
  output logic [2*WIDTH-1:0]   prod_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_step;

  // Low half of prod_q holds the unconsumed multiplier bits, high half the running sum.
  always_comb begin
    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {sum, prod_q[WIDTH-1:1]};
    prod_c    = prod_step;
    last_c    = step && (cnt_q == CNT_W'(1));
  end

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    if (load) begin
      mcand_d = a;
      prod_d  = {WIDTH'(0), b};
      cnt_d   = CNT_W'(WIDTH);
    end else if (step && (cnt_q != '0)) begin
      prod_d = prod_step;
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_param.sv
// Parametrised sequential ALU with operand registers, OFF/IDLE/EXEC/DONE control and flags.
// Define ALU_SEQ_MUL_EN to build in the iterative multiplier (out_sel[0]); otherwise MUL is invalid.
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [6:0]       out_sel,
  input  logic             start,
  output logic [WIDTH-1:0] final1,
  output logic [WIDTH-1:0] final2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             zero,
  output logic             err,
  output logic             busy,
  output logic             done,
  output logic [1:0]       curr_state,
  output logic [1:0]       next_state
);

`ifdef ALU_SEQ_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] final1_q, final1_d, final2_q, final2_d;
  logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [OP_W-1:0]  op_q, op_d;

  logic [WIDTH:0]   add_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

`ifdef ALU_SEQ_MUL_EN
  logic               mul_load, mul_step, mul_last_c;
  logic [2*WIDTH-1:0] mul_prod_c;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load),
    .step   (mul_step),
    .a      (final1_d),
    .b      (final2_d),
    .last_c (mul_last_c),
    .prod_c (mul_prod_c)
  );
`endif

  // Single-cycle datapath, evaluated on the registered operands during EXEC.
  always_comb begin
    add_ext   = {1'b0, final1_q} + {1'b0, final2_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    if (op_q[OP_ADD]) begin
      alu_res   = add_ext[WIDTH-1:0];
      alu_carry = add_ext[WIDTH];
    end else if (op_q[OP_SUB]) begin
      alu_res   = final1_q - final2_q;
      alu_carry = (final1_q < final2_q);
    end else if (op_q[OP_AND]) begin
      alu_res = final1_q & final2_q;
    end else if (op_q[OP_OR]) begin
      alu_res = final1_q | final2_q;
    end else if (op_q[OP_XOR]) begin
      alu_res = final1_q ^ final2_q;
    end else if (op_q[OP_NOT]) begin
      alu_res = ~final1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    final1_d = final1_q;
    final2_d = final2_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    op_d     = op_q;
`ifdef ALU_SEQ_MUL_EN
    mul_load = 1'b0;
    mul_step = 1'b0;
`endif

    if (!on) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_IDLE;
        ST_IDLE: begin
          if (in_sel[SEL_CLR]) begin
            final1_d = '0;
            final2_d = '0;
          end else if (in_sel[SEL_LOAD]) begin
            final1_d = num1;
            final2_d = num2;
          end
          // Multiplier captures final*_d so a same-cycle load is used directly.
          if (start) begin
            state_d = ST_EXEC;
            op_d    = out_sel;
`ifdef ALU_SEQ_MUL_EN
            mul_load = op_valid(out_sel, MUL_EN) && out_sel[OP_MUL];
`endif
          end
        end
        ST_EXEC: begin
          if (!op_valid(op_q, MUL_EN)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (op_q[OP_MUL]) begin
`ifdef ALU_SEQ_MUL_EN
            mul_step = 1'b1;
            if (mul_last_c) begin
              out_d    = mul_prod_c[WIDTH-1:0];
              out_hi_d = mul_prod_c[2*WIDTH-1:WIDTH];
              carry_d  = (mul_prod_c[2*WIDTH-1:WIDTH] != '0);
              zero_d   = (mul_prod_c == '0);
              err_d    = 1'b0;
              state_d  = ST_DONE;
            end
`endif
          end else begin
            out_d    = alu_res;
            out_hi_d = '0;
            carry_d  = alu_carry;
            zero_d   = (alu_res == '0);
            err_d    = 1'b0;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_OFF;
      endcase
    end

    busy_d = (state_d == ST_EXEC);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      final1_q <= '0;
      final2_q <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      final1_q <= final1_d;
      final2_q <= final2_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      op_q     <= op_d;
    end
  end

  assign final1     = final1_q;
  assign final2     = final2_q;
  assign out        = out_q;
  assign out_hi     = out_hi_q;
  assign carry      = carry_q;
  assign zero       = zero_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign curr_state = state_q;
  assign next_state = state_d;

endmodule
